player_l_ctrl: RTL and testbench

PLAYER_L_CTRL -- requirements
Module: player_l_ctrl

---
 rtl/player_pkg.sv | 60 ++++++
 rtl/frame_tick_gen.sv | 22 ++
 rtl/player_l_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_player_l_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// player_pkg: constants, state enumerations and helpers shared by the
// per-player controllers (player_l_ctrl, player_r_ctrl).
package player_pkg;

    // Gameplay defaults
    localparam int unsigned X_MAX       = 800;
    localparam int unsigned X_STEP      = 4;
    localparam int unsigned JUMP_V0     = 12;
    localparam int unsigned DEAD_FRAMES = 120;

    // Datapath widths
    localparam int unsigned POS_W   = 12;
    localparam int unsigned SWORD_W = 5;
    localparam int unsigned VEL_W   = 6;
    localparam int unsigned LEG_W   = 3;

    // Sword height levels
    localparam int unsigned SWORD_LOW  = 0;
    localparam int unsigned SWORD_MID  = 10;
    localparam int unsigned SWORD_HIGH = 20;

    // Thrust geometry
    localparam int unsigned THRUST_MAX  = 16;
    localparam int unsigned THRUST_STEP = 4;
    localparam int unsigned HOLD_TICKS  = 4;

    typedef enum logic [1:0] {
        ST_GROUND,
        ST_AIR,
        ST_DEAD
    } move_state_t;

    typedef enum logic [1:0] {
        TH_IDLE,
        TH_EXT,
        TH_HOLD,
        TH_RET
    } thrust_state_t;

    // Next sword level: one step up or down, saturating; simultaneous up+down holds.
    function automatic logic [SWORD_W-1:0] sword_next(input logic [SWORD_W-1:0] lvl,
                                                      input logic up,
                                                      input logic down);
        logic [SWORD_W-1:0] nxt;
        nxt = lvl;
        if (up && !down) begin
            if (lvl == SWORD_W'(SWORD_LOW))
                nxt = SWORD_W'(SWORD_MID);
            else if (lvl == SWORD_W'(SWORD_MID))
                nxt = SWORD_W'(SWORD_HIGH);
        end else if (down && !up) begin
            if (lvl == SWORD_W'(SWORD_HIGH))
                nxt = SWORD_W'(SWORD_MID);
            else if (lvl == SWORD_W'(SWORD_MID))
                nxt = SWORD_W'(SWORD_LOW);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: registered one-clk pulse on the clk after a vsync rising edge.
// Ports: clk, reset (sync, active-high), vsync_in, tick (registered pulse).
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic tick
);

    logic vsync_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev <= 1'b0;
            tick       <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            tick       <= vsync_in & ~vsync_prev;
        end
    end

endmodule

// File: rtl/player_l_ctrl.sv
// player_l_ctrl: per-frame movement, jump, sword and death control for player L.
// Ports: clk, reset (sync, active-high), vsync_in (frame timing),
//   btn_left/btn_right/btn_jump (level), btn_up/btn_down/btn_thrust (edge),
//   hit_L (strike pulse), round_restart (immediate respawn);
//   outputs LP_x_pos, LP_y_pos, LP_sword_pos, LP_x_sword_pos, change_legs_L, dead_L.
module player_l_ctrl #(
    parameter int unsigned X_MAX       = player_pkg::X_MAX,
    parameter int unsigned X_STEP      = player_pkg::X_STEP,
    parameter int unsigned JUMP_V0     = player_pkg::JUMP_V0,
    parameter int unsigned DEAD_FRAMES = player_pkg::DEAD_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vsync_in,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_jump,
    input  logic        btn_thrust,
    input  logic        hit_L,
    input  logic        round_restart,
    output logic [11:0] LP_x_pos,
    output logic [11:0] LP_y_pos,
    output logic [4:0]  LP_sword_pos,
    output logic [11:0] LP_x_sword_pos,
    output logic        change_legs_L,
    output logic        dead_L
);
    import player_pkg::*;

    localparam int unsigned DEAD_W = $clog2(DEAD_FRAMES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_TICKS);

    logic                     tick;
    move_state_t              state;
    thrust_state_t            th_state;
    logic signed [VEL_W-1:0]  vel;
    logic [LEG_W-1:0]         leg_cnt;
    logic [DEAD_W-1:0]        dead_cnt;
    logic [HOLD_W-1:0]        hold_cnt;
    logic                     hit_lat;
    logic                     up_prev;
    logic                     down_prev;
    logic                     thrust_prev;

    logic                     walk_c;
    logic                     respawn_c;
    logic                     up_new_c;
    logic                     down_new_c;
    logic                     thrust_new_c;
    logic                     land_c;
    logic [POS_W-1:0]         x_next_c;
    logic signed [POS_W:0]    y_sum_c;

    frame_tick_gen u_tick (
        .clk      (clk),
        .reset    (reset),
        .vsync_in (vsync_in),
        .tick     (tick)
    );

    // Per-tick decode: walking, edges, landing, respawn
    always_comb begin
        walk_c       = btn_left ^ btn_right;
        up_new_c     = btn_up & ~up_prev;
        down_new_c   = btn_down & ~down_prev;
        thrust_new_c = btn_thrust & ~thrust_prev;
        respawn_c    = reset | round_restart |
                       (tick && (state == ST_DEAD) && (dead_cnt == DEAD_W'(DEAD_FRAMES - 1)));
        // y is unsigned; extend both operands so a descent below ground shows as negative
        y_sum_c = $signed({1'b0, LP_y_pos}) +
                  $signed({{(POS_W + 1 - VEL_W){vel[VEL_W-1]}}, vel});
        land_c  = y_sum_c[POS_W] | (y_sum_c == '0);

        x_next_c = LP_x_pos;
        if (btn_right && !btn_left)
            x_next_c = (LP_x_pos >= POS_W'(X_MAX - X_STEP)) ? POS_W'(X_MAX)
                                                            : LP_x_pos + POS_W'(X_STEP);
        else if (btn_left && !btn_right)
            x_next_c = (LP_x_pos <= POS_W'(X_STEP)) ? '0 : LP_x_pos - POS_W'(X_STEP);
    end

    // Main movement FSM plus thrust sub-FSM; hit latch runs every clk
    always_ff @(posedge clk) begin
        if (respawn_c) begin
            state          <= ST_GROUND;
            th_state       <= TH_IDLE;
            LP_x_pos       <= '0;
            LP_y_pos       <= '0;
            LP_sword_pos   <= SWORD_W'(SWORD_LOW);
            LP_x_sword_pos <= '0;
            change_legs_L  <= 1'b0;
            dead_L         <= 1'b0;
            vel            <= '0;
            leg_cnt        <= '0;
            dead_cnt       <= '0;
            hold_cnt       <= '0;
            hit_lat        <= 1'b0;
            up_prev        <= 1'b0;
            down_prev      <= 1'b0;
            thrust_prev    <= 1'b0;
        end else begin
            if (state == ST_DEAD)
                hit_lat <= 1'b0;
            else if (hit_L)
                hit_lat <= 1'b1;

            if (tick) begin
                up_prev     <= btn_up;
                down_prev   <= btn_down;
                thrust_prev <= btn_thrust;

                if (state == ST_DEAD) begin
                    dead_cnt <= dead_cnt + DEAD_W'(1);
                end else if (hit_lat) begin
                    // A pending hit beats everything else on this tick, including a jump start
                    state          <= ST_DEAD;
                    dead_L         <= 1'b1;
                    dead_cnt       <= '0;
                    th_state       <= TH_IDLE;
                    LP_x_sword_pos <= '0;
                    hold_cnt       <= '0;
                end else begin
                    LP_x_pos <= x_next_c;
                    if (walk_c) begin
                        leg_cnt <= leg_cnt + LEG_W'(1);
                        if (leg_cnt == '1)
                            change_legs_L <= ~change_legs_L;
                    end
                    LP_sword_pos <= sword_next(LP_sword_pos, up_new_c, down_new_c);

                    case (state)
                        ST_GROUND: begin
                            if (btn_jump) begin
                                vel   <= VEL_W'(JUMP_V0);
                                state <= ST_AIR;
                            end
                        end
                        ST_AIR: begin
                            if (land_c) begin
                                LP_y_pos <= '0;
                                vel      <= '0;
                                state    <= ST_GROUND;
                            end else begin
                                LP_y_pos <= y_sum_c[POS_W-1:0];
                                vel      <= vel - VEL_W'(1);
                            end
                        end
                        default: ;
                    endcase

                    case (th_state)
                        TH_IDLE: begin
                            if (thrust_new_c)
                                th_state <= TH_EXT;
                        end
                        TH_EXT: begin
                            if (LP_x_sword_pos >= POS_W'(THRUST_MAX - THRUST_STEP)) begin
                                LP_x_sword_pos <= POS_W'(THRUST_MAX);
                                hold_cnt       <= '0;
                                th_state       <= TH_HOLD;
                            end else begin
                                LP_x_sword_pos <= LP_x_sword_pos + POS_W'(THRUST_STEP);
                            end
                        end
                        TH_HOLD: begin
                            if (hold_cnt == HOLD_W'(HOLD_TICKS - 1))
                                th_state <= TH_RET;
                            else
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                        TH_RET: begin
                            if (LP_x_sword_pos <= POS_W'(THRUST_STEP)) begin
                                LP_x_sword_pos <= '0;
                                th_state       <= TH_IDLE;
                            end else begin
                                LP_x_sword_pos <= LP_x_sword_pos - POS_W'(THRUST_STEP);
                            end
                        end
                        default: th_state <= TH_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_player_l_ctrl.sv
// tb_player_l_ctrl: directed frames with hand-computed expectations queued
// to a scoreboard; a monitor pops and compares when each frame's output lands.
`timescale 1ns/1ps
module tb_player_l_ctrl;

    logic        clk = 1'b0;
    logic        reset, vsync_in, btn_left, btn_right, btn_up, btn_down;
    logic        btn_jump, btn_thrust, hit_L, round_restart;
    logic [11:0] LP_x_pos, LP_y_pos, LP_x_sword_pos;
    logic [4:0]  LP_sword_pos;
    logic        change_legs_L, dead_L;

    always #5 clk = ~clk;

    player_l_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .vsync_in       (vsync_in),
        .btn_left       (btn_left),
        .btn_right      (btn_right),
        .btn_up         (btn_up),
        .btn_down       (btn_down),
        .btn_jump       (btn_jump),
        .btn_thrust     (btn_thrust),
        .hit_L          (hit_L),
        .round_restart  (round_restart),
        .LP_x_pos       (LP_x_pos),
        .LP_y_pos       (LP_y_pos),
        .LP_sword_pos   (LP_sword_pos),
        .LP_x_sword_pos (LP_x_sword_pos),
        .change_legs_L  (change_legs_L),
        .dead_L         (dead_L)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
        logic [4:0]  sw;
        logic [11:0] xs;
        logic        legs;
        logic        dead;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    event  out_ev;

    // Expected-state model, set by hand in the stimulus
    int   m_x, m_y, m_sw, m_xs, walk_cnt;
    logic m_dead;

    int jump_y [25] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                        77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};
    int thrust_xs [12] = '{4, 8, 12, 16, 16, 16, 16, 16, 12, 8, 4, 0};
    int up_seq [3]   = '{10, 20, 20};
    int down_seq [3] = '{10, 0, 0};

    task automatic zero_model();
        m_x = 0; m_y = 0; m_sw = 0; m_xs = 0; walk_cnt = 0; m_dead = 1'b0;
    endtask

    task automatic expect_now(input string nm);
        obs_t e;
        e.x    = 12'(m_x);
        e.y    = 12'(m_y);
        e.sw   = 5'(m_sw);
        e.xs   = 12'(m_xs);
        e.legs = walk_cnt[3];
        e.dead = m_dead;
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> out_ev;
    endtask

    // One vsync pulse; outputs settle on the second edge, checked at the following negedge
    task automatic frame(input string nm);
        vsync_in = 1'b1;
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        expect_now(nm);
    endtask

    task automatic restart(input string nm);
        round_restart = 1'b1;
        @(negedge clk);
        round_restart = 1'b0;
        zero_model();
        expect_now(nm);
    endtask

    task automatic pulse_hit();
        hit_L = 1'b1;
        @(negedge clk);
        hit_L = 1'b0;
        @(negedge clk);
    endtask

    // Scoreboard monitor
    initial begin
        obs_t  e, g;
        string nm;
        forever begin
            @(out_ev);
            g.x = LP_x_pos; g.y = LP_y_pos; g.sw = LP_sword_pos;
            g.xs = LP_x_sword_pos; g.legs = change_legs_L; g.dead = dead_L;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: output seen with no expectation queued");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL %s: got x=%0d y=%0d sw=%0d xs=%0d legs=%0b dead=%0b, expected x=%0d y=%0d sw=%0d xs=%0d legs=%0b dead=%0b",
                             nm, g.x, g.y, g.sw, g.xs, g.legs, g.dead,
                             e.x, e.y, e.sw, e.xs, e.legs, e.dead);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; vsync_in = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_jump = 1'b0; btn_thrust = 1'b0;
        hit_L = 1'b0; round_restart = 1'b0;
        zero_model();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        expect_now("reset_state");

        // Walk right to the right wall
        btn_right = 1'b1;
        for (int n = 1; n <= 210; n++) begin
            walk_cnt++;
            m_x = (n * 4 > 800) ? 800 : n * 4;
            frame("walk_right");
        end
        btn_left = 1'b1;
        for (int n = 0; n < 3; n++) frame("both_hold");
        btn_right = 1'b0;
        for (int n = 0; n < 3; n++) begin
            walk_cnt++;
            m_x = m_x - 4;
            frame("walk_left");
        end
        btn_left = 1'b0;

        restart("restart_clears_x");
        btn_left = 1'b1;
        for (int n = 0; n < 2; n++) begin
            walk_cnt++;
            frame("left_wall");
        end
        btn_left = 1'b0;

        // Single jump
        btn_jump = 1'b1;
        frame("jump_start");
        btn_jump = 1'b0;
        for (int i = 0; i < 25; i++) begin
            m_y = jump_y[i];
            frame("jump_arc");
        end
        btn_jump = 1'b1;
        frame("rejump_start");
        btn_jump = 1'b0;
        m_y = 12;
        frame("rejump_rise");
        restart("restart_mid_jump");

        // Sword levels
        for (int i = 0; i < 3; i++) begin
            btn_up = 1'b1; m_sw = up_seq[i]; frame("sword_up");
            btn_up = 1'b0; frame("sword_up_release");
        end
        for (int i = 0; i < 3; i++) begin
            btn_down = 1'b1; m_sw = down_seq[i]; frame("sword_down");
            btn_down = 1'b0; frame("sword_down_release");
        end
        btn_up = 1'b1;
        m_sw = 10;
        for (int i = 0; i < 5; i++) frame("sword_up_held");
        btn_up = 1'b0;
        frame("sword_up_held_release");
        btn_up = 1'b1; btn_down = 1'b1;
        frame("sword_up_down_together");
        btn_up = 1'b0; btn_down = 1'b0;

        // Thrust with a second press during hold
        btn_thrust = 1'b1;
        frame("thrust_press");
        btn_thrust = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) btn_thrust = 1'b1;
            m_xs = thrust_xs[i];
            frame("thrust_profile");
            btn_thrust = 1'b0;
        end
        frame("thrust_idle_after");

        // Hit mid-jump at x=100, then timed respawn
        restart("restart_before_hit");
        btn_right = 1'b1;
        for (int n = 1; n <= 25; n++) begin
            walk_cnt++;
            m_x = n * 4;
            frame("walk_to_100");
        end
        btn_right = 1'b0;
        btn_jump = 1'b1;
        frame("hit_jump_start");
        btn_jump = 1'b0;
        btn_thrust = 1'b1; m_y = 12;
        frame("hit_jump_thrust");
        btn_thrust = 1'b0; m_y = 23; m_xs = 4;
        frame("hit_jump_rise");
        m_y = 33; m_xs = 8;
        frame("hit_jump_rise2");
        pulse_hit();
        m_dead = 1'b1; m_xs = 0;
        frame("hit_dead");
        for (int k = 1; k <= 119; k++) begin
            if (k == 1) begin
                btn_right = 1'b1; btn_up = 1'b1; btn_thrust = 1'b1; hit_L = 1'b1;
            end
            if (k == 60) begin
                btn_right = 1'b0; btn_up = 1'b0; btn_thrust = 1'b0; hit_L = 1'b0;
            end
            frame("dead_frozen");
        end
        zero_model();
        frame("dead_timeout_respawn");

        // Hit arriving with a jump start wins; restart during DEAD
        btn_jump = 1'b1;
        pulse_hit();
        m_dead = 1'b1;
        frame("hit_beats_jump");
        btn_jump = 1'b0;
        for (int k = 1; k <= 9; k++) frame("dead_before_restart");
        restart("restart_in_dead");
        frame("alive_after_restart");

        // Reset during thrust extension
        btn_thrust = 1'b1;
        frame("reset_thrust_press");
        btn_thrust = 1'b0;
        m_xs = 4;
        frame("reset_thrust_ext1");
        m_xs = 8;
        frame("reset_thrust_ext2");
        reset = 1'b1;
        @(negedge clk);
        zero_model();
        expect_now("reset_mid_thrust");
        reset = 1'b0;
        frame("after_reset_idle");

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
